// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC expansion-bus cycle initiator: turns valid/ready commands into
// T-state-accurate IO/memory strobes, honours wait states and reports results.
module cpc_bus_initiator #(
  parameter logic [7:0]  IO_PORT_HI = 8'h7F,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_adr,
  input  logic [7:0]  cmd_data,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_ext,
  output logic        resp_err,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        iorq_b,
  output logic        mreq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        ramrd_b,
  input  logic        ready,
  input  logic        ramdis
);

  typedef enum logic [2:0] {IDLE, T1, T2, TWA, TW, T3, DONE} state_t;
  typedef enum logic [1:0] {
    OP_BANK = 2'b00,
    OP_MWR  = 2'b01,
    OP_MRD  = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  localparam logic [8:0] WAIT_LIM = 9'(WAIT_LIMIT);

  state_t     state, state_n;
  op_t        op_q, op_n;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       timeout;
  logic       active_n;
  logic       iorq_nx, mreq_nx, rd_nx, wr_nx, ramrd_nx, oe_nx;

  assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
  assign timeout = !ready && (({1'b0, wait_cnt} + 9'd1) >= WAIT_LIM);

  always_comb begin
    state_n = state;
    op_n    = accept ? op_t'(cmd_op) : op_q;
    case (state)
      IDLE: if (accept) state_n = (op_t'(cmd_op) == OP_NOP) ? DONE : T1;
      T1:   state_n = T2;
      T2: begin
        if (op_q == OP_BANK) state_n = TWA;
        else if (ready)      state_n = T3;
        else                 state_n = TW;
      end
      TWA:  state_n = ready ? T3 : TW;
      TW: begin
        if (ready)        state_n = T3;
        else if (timeout) state_n = DONE;
      end
      T3:   state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are computed from the next state so the registered outputs line
  // up exactly with the T-state they belong to.
  always_comb begin
    iorq_nx  = 1'b1;
    mreq_nx  = 1'b1;
    rd_nx    = 1'b1;
    wr_nx    = 1'b1;
    ramrd_nx = 1'b1;
    oe_nx    = 1'b0;
    active_n = (state_n == T1) || (state_n == T2) || (state_n == TWA) ||
               (state_n == TW) || (state_n == T3);
    if (active_n) begin
      case (op_n)
        OP_BANK: begin
          oe_nx = 1'b1;
          if (state_n != T1) begin
            iorq_nx = 1'b0;
            wr_nx   = 1'b0;
          end
        end
        OP_MWR: begin
          oe_nx   = 1'b1;
          mreq_nx = 1'b0;
          if (state_n != T1) wr_nx = 1'b0;
        end
        OP_MRD: begin
          mreq_nx  = 1'b0;
          rd_nx    = 1'b0;
          ramrd_nx = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_BANK;
      wait_cnt   <= '0;
      cmd_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_ext   <= 1'b0;
      resp_err   <= 1'b0;
      adr        <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      iorq_b     <= 1'b1;
      mreq_b     <= 1'b1;
      rd_b       <= 1'b1;
      wr_b       <= 1'b1;
      ramrd_b    <= 1'b1;
    end else begin
      state      <= state_n;
      op_q       <= op_n;
      cmd_ready  <= (state_n == IDLE);
      resp_valid <= (state_n == DONE);
      data_oe    <= oe_nx;
      iorq_b     <= iorq_nx;
      mreq_b     <= mreq_nx;
      rd_b       <= rd_nx;
      wr_b       <= wr_nx;
      ramrd_b    <= ramrd_nx;

      if (accept) begin
        case (op_t'(cmd_op))
          OP_BANK: begin
            adr      <= {IO_PORT_HI, 8'h00};
            data_out <= {2'b11, cmd_data[5:0]};
          end
          OP_MWR: begin
            adr      <= cmd_adr;
            data_out <= cmd_data;
          end
          OP_MRD:  adr <= cmd_adr;
          default: ;
        endcase
      end

      if (state_n == T1)     wait_cnt <= '0;
      else if (state == TW)  wait_cnt <= wait_cnt + 8'd1;

      // Response fields change only on entry to DONE and hold afterwards.
      if (state == T3) begin
        resp_data <= (op_q == OP_MRD) ? data_in : 8'h00;
        resp_ext  <= ramdis;
        resp_err  <= 1'b0;
      end else if ((state == TW) && (state_n == DONE)) begin
        resp_data <= 8'h00;
        resp_ext  <= 1'b0;
        resp_err  <= 1'b1;
      end else if (accept && (state_n == DONE)) begin
        resp_data <= 8'h00;
        resp_ext  <= 1'b0;
        resp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cpc_bus_initiator.md
# cpc_bus_initiator

Z80-style bus-cycle initiator that drives the CPC expansion bus as the host CPU would. It accepts simple commands over a valid/ready interface: bank-configuration IO writes to port 0x7Fxx, memory writes and memory reads. It sequences T-state-accurate strobes, honours bus wait states and reports read data together with whether the RAM expansion claimed the access (ramdis). It sits upstream of the 512K RAM expansion logic on the test/host side and supplies the configuration writes and memory traffic that the expansion decodes.

## Interface
Parameters:
- IO_PORT_HI, 8'h7F, high address byte driven for bank-configuration IO writes.
- WAIT_LIMIT, 255, maximum consecutive wait states before a cycle is aborted (8-bit counter).

Ports:
- clk  in  1  system clock; one clk period = one T-state.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  initiator idle and able to accept a command.
- cmd_op  in  2  00 = bank config IO write, 01 = mem write, 10 = mem read, 11 = reserved (treated as no-op).
- cmd_adr  in  16  memory address; ignored for op 00.
- cmd_data  in  8  write data; for op 00 only bits [5:0] (cccbbb) are used.
- resp_valid  out  1  one-cycle pulse when a command completes.
- resp_data  out  8  read data captured for op 10; 8'h00 otherwise.
- resp_ext  out  1  ramdis sampled at T3 (1 = expansion claimed the access).
- resp_err  out  1  cycle aborted on wait timeout.
- adr  out  16  bus address (adr[15], adr[14] feed the expansion decode).
- data_out  out  8  bus write data.
- data_oe  out  1  data_out drive enable.
- data_in  in  8  bus read data.
- iorq_b, mreq_b, rd_b, wr_b, ramrd_b  out  1 each  active-low bus strobes.
- ready  in  1  bus ready; 0 inserts wait states.
- ramdis  in  1  RAM-expansion claim indication.

## Operation
- States: IDLE, T1, T2, TWA (IO only), TW, T3, DONE.
- A command is accepted in IDLE when cmd_valid && cmd_ready; op, adr and data are registered, and the state moves to T1.
- Op 11 goes directly to DONE: resp_valid is pulsed with resp_data = 0, resp_ext = 0 and resp_err = 0, and no strobes are asserted.
- Bank write: adr = {IO_PORT_HI, 8'h00} and data_out = {2'b11, cmd_data[5:0]}.
  - iorq_b and wr_b are low in T2, TWA, TW and T3.
  - data_oe is high from T1 to T3.
- Mem write: adr = cmd_adr.
  - mreq_b is low in T1 to T3.
  - wr_b is low in T2 to T3.
  - data_oe is high from T1 to T3.
- Mem read: adr = cmd_adr.
  - mreq_b, rd_b and ramrd_b are low in T1 to T3.
  - data_oe stays 0.
  - data_in is captured at the end of T3.
- ready is sampled at the end of T2 for memory cycles and at the end of TWA for IO cycles. If ready = 0, the state moves to TW and stays there until ready = 1, then moves to T3.
- The wait counter is cleared on entry to T1 and increments each TW cycle. When it reaches WAIT_LIMIT while ready = 0:
  - all strobes deassert next cycle;
  - the state moves to DONE with resp_err = 1 and resp_data = 0.
- At the end of T3, ramdis is sampled into resp_ext.
- DONE pulses resp_valid for one cycle and returns to IDLE; strobes are already deasserted in DONE.
- Outside an active cycle:
  - all *_b outputs = 1, data_oe = 0;
  - adr and data_out hold their last values.
- resp_* outputs hold until the next completion.

## Timing
- Reset values:
  - cmd_ready = 0 during reset and 1 in the first cycle after reset;
  - resp_valid = 0, resp_data = 8'h00, resp_ext = 0, resp_err = 0;
  - adr = 16'h0000, data_out = 8'h00, data_oe = 0;
  - all strobes = 1; state = IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency from the accept edge to the resp_valid pulse, with zero waits:
  - mem read/write: 4 cycles (T1, T2, T3, DONE);
  - bank write: 5 cycles;
  - plus one cycle per wait state.
- cmd_ready is 0 from the accept cycle through DONE. It is 1 again in the IDLE cycle after DONE, so a back-to-back command may be accepted the cycle after resp_valid.
- Reset mid-cycle (any state):
  - the next cycle has all strobes = 1, data_oe = 0, state = IDLE;
  - no resp_valid is issued for the interrupted command.
- cmd_valid is ignored while cmd_ready = 0; changing cmd_* mid-cycle has no effect.

## Test plan
- Reset, then a bank write with cmd_data = 6'b001010 and ready = 1:
  - adr = 16'h7F00, data_out = 8'hCA;
  - iorq_b/wr_b low for exactly 3 cycles;
  - resp_valid at accept + 5, resp_err = 0.
- Mem read at adr 16'hC123 with data_in = 8'h5A and ramdis = 1:
  - mreq_b/rd_b/ramrd_b low for 3 cycles, wr_b = 1;
  - resp_data = 8'h5A, resp_ext = 1 at accept + 4.
- Mem write at 16'h4000 with data 8'hA5, holding ready = 0 for 3 cycles after T2:
  - exactly 3 TW cycles, wr_b low T2 to T3;
  - resp_valid at accept + 7.
- Hold ready = 0 indefinitely with WAIT_LIMIT = 4:
  - strobes release after 4 TW cycles;
  - resp_err = 1, resp_data = 0, cmd_ready returns to 1.
- Assert reset while in TW of a mem write: next cycle all strobes = 1, data_oe = 0, no resp_valid, and cmd_ready = 1 after reset drops.
- Back-to-back commands with cmd_valid held high, then op 11:
  - the second command is accepted the cycle after the first resp_valid;
  - op 11 gives resp_valid at accept + 1 with no strobe activity.
